// File: rtl/uart_tx_fifo_if.sv
// Host write port and transmitter start/done handshake of the UART TX buffer.
// The master side is the host plus the transmitter; the slave side is uart_tx_fifo.
interface uart_tx_fifo_if #(
   parameter int NB_DATA = 8,
   parameter int NB_ADDR = 4
);
   logic               wr;
   logic [NB_DATA-1:0] wr_data;
   logic               full;
   logic               empty;
   logic [NB_ADDR:0]   count;
   logic               overflow;
   logic               busy;
   logic               tx_start;
   logic [NB_DATA-1:0] tx_data;
   logic               tx_done;

   modport master (
      output wr, wr_data, tx_done,
      input  full, empty, count, overflow, busy, tx_start, tx_data
   );

   modport slave (
      input  wr, wr_data, tx_done,
      output full, empty, count, overflow, busy, tx_start, tx_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus start/done sequencer feeding the UART transmitter, one byte in flight at a time.
// Writes into a full FIFO are dropped and flagged; a write is still taken when full if the head pops that cycle.
module uart_tx_fifo #(
   parameter int NB_DATA = 8,
   parameter int NB_ADDR = 4
) (
   input  logic           i_clk,
   input  logic           i_reset,
   uart_tx_fifo_if.slave  bus
);
   localparam int DEPTH = 2 ** NB_ADDR;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t             state;
   logic [NB_DATA-1:0] mem [DEPTH];
   logic [NB_ADDR-1:0] wr_ptr;
   logic [NB_ADDR-1:0] rd_ptr;
   logic [NB_ADDR:0]   count;
   logic               pop;
   logic               accept;

   assign pop       = (state == ST_IDLE) && (count != '0);
   assign accept    = bus.wr && (!bus.full || pop);
   assign bus.full  = (count == (NB_ADDR+1)'(DEPTH));
   assign bus.empty = (count == '0);
   assign bus.count = count;

   // Storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= ST_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         bus.overflow <= 1'b0;
         bus.busy     <= 1'b0;
         bus.tx_start <= 1'b0;
         bus.tx_data  <= '0;
      end else begin
         bus.overflow <= bus.wr && !accept;

         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         if (accept && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !accept) begin
            count <= count - 1'b1;
         end

         case (state)
            ST_IDLE: begin
               bus.tx_start <= 1'b0;
               if (pop) begin
                  bus.tx_data  <= mem[rd_ptr];
                  rd_ptr       <= rd_ptr + 1'b1;
                  bus.tx_start <= 1'b1;
                  bus.busy     <= 1'b1;
                  state        <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // tx_data is left untouched so the transmitter sees it stable until done.
               bus.tx_start <= 1'b0;
               if (bus.tx_done) begin
                  bus.busy <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a transmitter responder answers starts with done pulses,
// and a monitor checks every start against a queue of expected bytes and start cycles.
module tb_uart_tx_fifo;
   localparam int NB_DATA = 8;
   localparam int NB_ADDR = 4;

   logic i_clk = 1'b0;
   logic i_reset;
   always #5 i_clk = ~i_clk;

   uart_tx_fifo_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

   uart_tx_fifo #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   int             cyc = 0;
   int             n_chk = 0;
   int             n_pass = 0;
   int             n_starts = 0;
   int             n_ovf = 0;
   int             exp_start = -1;
   int             done_delay = 20;
   bit             hold = 1'b0;
   logic [7:0]     inflight = 8'h00;
   logic [7:0]     exp_q [$];

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Transmitter model: done pulse done_delay cycles after start, withheld while hold is set.
   initial begin : responder
      bit pend = 1'b0;
      int wait_cnt = 0;
      bus.tx_done = 1'b0;
      forever begin
         @(posedge i_clk); #2;
         bus.tx_done = 1'b0;
         if (i_reset) begin
            pend = 1'b0;
         end else if (bus.tx_start) begin
            pend = 1'b1;
            wait_cnt = 0;
         end else if (pend) begin
            wait_cnt++;
            if (!hold && wait_cnt >= done_delay) begin
               bus.tx_done = 1'b1;
               pend = 1'b0;
            end
         end
      end
   end

   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge i_clk);
         if (!i_reset && bus.overflow) n_ovf++;
         if (!i_reset && bus.tx_start) begin
            n_starts++;
            check("start_expected", 32'(exp_q.size() != 0), 1);
            check("busy_at_start", bus.busy, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("tx_data", bus.tx_data, e);
               inflight = e;
            end
            if (exp_start >= 0) check("start_cycle", cyc, exp_start);
            exp_start = -1;
         end
         if (!i_reset && bus.tx_done && bus.busy) begin
            check("data_held_to_done", bus.tx_data, inflight);
            if (exp_q.size() != 0) exp_start = cyc + 2;
         end
      end
   end

   task automatic wr_byte(input logic [7:0] d, input bit accept);
      @(posedge i_clk); #1;
      if (accept && exp_q.size() == 0 && !bus.busy) exp_start = cyc + 2;
      if (accept) exp_q.push_back(d);
      bus.wr = 1'b1;
      bus.wr_data = d;
   endtask

   task automatic wr_idle();
      @(posedge i_clk); #1;
      bus.wr = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while ((exp_q.size() != 0 || bus.busy) && n < max_cyc);
      check({name, "_drained"}, 32'(exp_q.size() == 0 && !bus.busy), 1);
      check({name, "_count0"}, bus.count, 0);
      check({name, "_empty"}, bus.empty, 1);
   endtask

   initial begin : stim
      int starts_before;
      i_reset = 1'b1;
      bus.wr = 1'b0;
      bus.wr_data = 8'h00;

      // 1: reset state
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_count", bus.count, 0);
      check("rst_tx_start", bus.tx_start, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_overflow", bus.overflow, 0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;

      // 2: single byte
      done_delay = 20;
      wr_byte(8'hA5, 1'b1);
      wr_idle();
      wait_idle("single", 200);

      // 3: three back-to-back bytes, slow transmitter
      done_delay = 30;
      wr_byte(8'h11, 1'b1);
      wr_byte(8'h22, 1'b1);
      wr_byte(8'h33, 1'b1);
      wr_idle();
      wait_idle("three", 300);

      // 4: fill with done withheld, then one dropped write
      hold = 1'b1;
      done_delay = 3;
      for (int i = 0; i < 17; i++) wr_byte(8'(i), 1'b1);
      wr_byte(8'hFF, 1'b0);
      @(negedge i_clk);
      check("full_count", bus.count, 16);
      check("full_flag", bus.full, 1);
      check("full_ovf_before", bus.overflow, 0);
      wr_idle();
      @(negedge i_clk);
      check("ovf_pulse", bus.overflow, 1);
      @(negedge i_clk);
      check("ovf_single", bus.overflow, 0);
      check("full_count_kept", bus.count, 16);
      check("ovf_total", n_ovf, 1);

      // 5: release done, write 0x77 in the pop cycle
      hold = 1'b0;
      @(posedge i_clk); #1;
      wr_byte(8'h77, 1'b1);
      wr_idle();
      @(negedge i_clk);
      check("popwr_count", bus.count, 16);
      check("popwr_full", bus.full, 1);
      check("popwr_no_ovf", bus.overflow, 0);
      wait_idle("full_drain", 600);
      check("ovf_total_end", n_ovf, 1);

      // 6: reset while waiting with 5 bytes queued
      hold = 1'b1;
      for (int i = 0; i < 6; i++) wr_byte(8'h50 + 8'(i), 1'b1);
      wr_idle();
      repeat (5) @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      exp_q.delete();
      exp_start = -1;
      starts_before = n_starts;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      @(negedge i_clk);
      check("midrst_busy", bus.busy, 0);
      check("midrst_count", bus.count, 0);
      check("midrst_empty", bus.empty, 1);
      check("midrst_tx_data", bus.tx_data, 0);
      hold = 1'b0;
      done_delay = 5;
      repeat (10) @(negedge i_clk);
      check("midrst_no_start", n_starts, starts_before);
      wr_byte(8'h3C, 1'b1);
      wr_idle();
      wait_idle("after_rst", 100);
      check("after_rst_starts", n_starts, starts_before + 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
